i_fetch: RTL and testbench

I_FETCH -- requirements
Module: i_fetch

---
 rtl/i_fetch_pkg.sv | 23 ++
 rtl/i_fetch_if.sv | 24 ++
 rtl/i_fetch_imem.sv | 17 +
 rtl/i_fetch.sv | 53 +++++
 tb/tb_i_fetch.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/i_fetch_pkg.sv
// Shared constants and the fixed instruction ROM image for the fetch stage.
package i_fetch_pkg;

   localparam int unsigned          WORD_W         = 32;
   localparam int unsigned          IMEM_DEPTH_DEF = 128;
   localparam logic [WORD_W-1:0]    NOP            = 32'h0000_0000;

   // ROM image: the first five words carry a program, everything else reads as NOP.
   function automatic logic [WORD_W-1:0] rom_word(input logic [31:0] idx);
      logic [WORD_W-1:0] w;
      w = NOP;
      case (idx)
         32'd0:   w = 32'hA000_00AA;
         32'd1:   w = 32'h1000_0011;
         32'd2:   w = 32'h2000_0022;
         32'd3:   w = 32'h3000_0033;
         32'd4:   w = 32'h4000_0044;
         default: w = NOP;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/i_fetch_if.sv
// Branch-redirect inputs and IF/ID latch outputs of the fetch stage.
interface i_fetch_if;
   import i_fetch_pkg::*;

   logic              PC_Src;
   logic [WORD_W-1:0] EX_MEM_NPC;
   logic [WORD_W-1:0] IF_ID_IR;
   logic [WORD_W-1:0] IF_ID_NPC;

   modport master (
      output PC_Src,
      output EX_MEM_NPC,
      input  IF_ID_IR,
      input  IF_ID_NPC
   );

   modport slave (
      input  PC_Src,
      input  EX_MEM_NPC,
      output IF_ID_IR,
      output IF_ID_NPC
   );

endinterface

// File: rtl/i_fetch_imem.sv
// Combinational instruction ROM; contents fixed at elaboration.
module i_fetch_imem
   import i_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = IMEM_DEPTH_DEF,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic [AW-1:0]     addr,
   output logic [WORD_W-1:0] data
);

   // Asynchronous read straight from the elaborated image.
   always_comb begin
      data = rom_word(32'(addr));
   end

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch stage: PC register, branch mux, ROM lookup and IF/ID latch.
module i_fetch
   import i_fetch_pkg::*;
#(
   parameter int unsigned       IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter logic [WORD_W-1:0] PC_RESET   = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   i_fetch_if.slave    bus
);

   localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

   logic [WORD_W-1:0] pc_q,  pc_d;
   logic [WORD_W-1:0] ir_q,  ir_d;
   logic [WORD_W-1:0] npc_q, npc_d;
   logic [WORD_W-1:0] pc_inc;
   logic [WORD_W-1:0] rom_data;

   // Upper PC bits are dropped here, so fetch addresses alias modulo the ROM depth.
   i_fetch_imem #(
      .DEPTH (IMEM_DEPTH)
   ) u_imem (
      .addr (pc_q[AW-1:0]),
      .data (rom_data)
   );

   // Next PC selection and IF/ID latch inputs; the increment wraps naturally at 2^32.
   always_comb begin
      pc_inc = pc_q + 32'd1;
      pc_d   = bus.PC_Src ? bus.EX_MEM_NPC : pc_inc;
      ir_d   = rom_data;
      npc_d  = pc_inc;
   end

   // State update; reset wins over a branch and discards the in-flight fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= PC_RESET;
         ir_q  <= NOP;
         npc_q <= '0;
      end else begin
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         npc_q <= npc_d;
      end
   end

   assign bus.IF_ID_IR  = ir_q;
   assign bus.IF_ID_NPC = npc_q;

endmodule

// File: tb/tb_i_fetch.sv
// Self-checking bench for i_fetch: directed scenarios plus a randomized run
// compared against a behavioural fetch model.
module tb_i_fetch;

   localparam int unsigned DEPTH = 128;
   localparam logic [31:0] PCR   = 32'd0;

   logic clk;
   logic rst;

   i_fetch_if bus ();

   i_fetch #(
      .IMEM_DEPTH (DEPTH),
      .PC_RESET   (PCR)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run;
   int tests_failed;

   // Behavioural model: program image, architectural PC, expected latch contents.
   logic [31:0] rom_m [DEPTH];
   logic [31:0] m_pc;
   logic [31:0] exp_ir;
   logic [31:0] exp_npc;

   // Drive one edge's inputs (optionally with a glitch between edges first),
   // clock it, and advance the model. Sampling happens #1 after the edge.
   task automatic cycle(input logic r, input logic s, input logic [31:0] t,
                        input logic glitch);
      if (glitch) begin
         bus.PC_Src     = ~s;
         bus.EX_MEM_NPC = ~t;
         #3;
      end
      rst            = r;
      bus.PC_Src     = s;
      bus.EX_MEM_NPC = t;
      @(posedge clk);
      #1;
      if (r) begin
         exp_ir  = 32'h0;
         exp_npc = 32'h0;
         m_pc    = PCR;
      end else begin
         exp_ir  = rom_m[m_pc % DEPTH];
         exp_npc = m_pc + 32'd1;
         m_pc    = s ? t : m_pc + 32'd1;
      end
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      tests_run++;
      if (bus.IF_ID_IR !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_ir: got %h expected %h", bus.IF_ID_IR, 32'h0);
      end
      tests_run++;
      if (bus.IF_ID_NPC !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_npc: got %h expected %h", bus.IF_ID_NPC, 32'h0);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] want_ir [6];
      want_ir = '{32'hA00000AA, 32'h10000011, 32'h20000022,
                  32'h30000033, 32'h40000044, 32'h00000000};
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b0, 32'd0, 1'b0);
         tests_run++;
         if (bus.IF_ID_IR !== want_ir[i]) begin
            tests_failed++;
            $display("FAIL seq_ir[%0d]: got %h expected %h", i, bus.IF_ID_IR, want_ir[i]);
         end
         tests_run++;
         if (bus.IF_ID_NPC !== 32'(i + 1)) begin
            tests_failed++;
            $display("FAIL seq_npc[%0d]: got %h expected %h", i, bus.IF_ID_NPC, 32'(i + 1));
         end
      end
   endtask

   task automatic test_branch();
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 1'b1, 32'd0, 1'b0);
      tests_run++;
      if (bus.IF_ID_IR !== 32'h20000022 || bus.IF_ID_NPC !== 32'd3) begin
         tests_failed++;
         $display("FAIL branch_edge: got %h/%h expected %h/%h",
                  bus.IF_ID_IR, bus.IF_ID_NPC, 32'h20000022, 32'd3);
      end
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      tests_run++;
      if (bus.IF_ID_IR !== 32'hA00000AA || bus.IF_ID_NPC !== 32'd1) begin
         tests_failed++;
         $display("FAIL branch_target: got %h/%h expected %h/%h",
                  bus.IF_ID_IR, bus.IF_ID_NPC, 32'hA00000AA, 32'd1);
      end
   endtask

   task automatic test_alias();
      cycle(1'b0, 1'b1, 32'd129, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      tests_run++;
      if (bus.IF_ID_IR !== 32'h10000011 || bus.IF_ID_NPC !== 32'd130) begin
         tests_failed++;
         $display("FAIL alias: got %h/%h expected %h/%h",
                  bus.IF_ID_IR, bus.IF_ID_NPC, 32'h10000011, 32'd130);
      end
   endtask

   task automatic test_wrap();
      cycle(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      tests_run++;
      if (bus.IF_ID_IR !== 32'h0 || bus.IF_ID_NPC !== 32'h0) begin
         tests_failed++;
         $display("FAIL wrap_top: got %h/%h expected %h/%h",
                  bus.IF_ID_IR, bus.IF_ID_NPC, 32'h0, 32'h0);
      end
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      tests_run++;
      if (bus.IF_ID_IR !== 32'hA00000AA || bus.IF_ID_NPC !== 32'd1) begin
         tests_failed++;
         $display("FAIL wrap_zero: got %h/%h expected %h/%h",
                  bus.IF_ID_IR, bus.IF_ID_NPC, 32'hA00000AA, 32'd1);
      end
   endtask

   task automatic test_priority();
      cycle(1'b1, 1'b1, 32'd3, 1'b0);
      tests_run++;
      if (bus.IF_ID_IR !== 32'h0 || bus.IF_ID_NPC !== 32'h0) begin
         tests_failed++;
         $display("FAIL prio_rst: got %h/%h expected %h/%h",
                  bus.IF_ID_IR, bus.IF_ID_NPC, 32'h0, 32'h0);
      end
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      tests_run++;
      if (bus.IF_ID_IR !== 32'hA00000AA || bus.IF_ID_NPC !== 32'd1) begin
         tests_failed++;
         $display("FAIL prio_after: got %h/%h expected %h/%h",
                  bus.IF_ID_IR, bus.IF_ID_NPC, 32'hA00000AA, 32'd1);
      end
   endtask

   task automatic test_midrun_reset();
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      tests_run++;
      if (bus.IF_ID_IR !== 32'h0 || bus.IF_ID_NPC !== 32'h0) begin
         tests_failed++;
         $display("FAIL midrst_edge: got %h/%h expected %h/%h",
                  bus.IF_ID_IR, bus.IF_ID_NPC, 32'h0, 32'h0);
      end
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      tests_run++;
      if (bus.IF_ID_IR !== 32'hA00000AA || bus.IF_ID_NPC !== 32'd1) begin
         tests_failed++;
         $display("FAIL midrst_after: got %h/%h expected %h/%h",
                  bus.IF_ID_IR, bus.IF_ID_NPC, 32'hA00000AA, 32'd1);
      end
   endtask

   // Random mix of resets, branches (near the program, aliased and far) and
   // inter-edge glitches on the branch inputs, checked against the model.
   task automatic test_random();
      logic        r, s, g;
      logic [31:0] t;
      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 19) == 0);
         s = ($urandom_range(0, 3) == 0);
         g = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 2))
            0:       t = 32'($urandom_range(0, 7));
            1:       t = 32'($urandom_range(0, 3)) + 32'(DEPTH * $urandom_range(1, 5));
            default: t = $urandom;
         endcase
         cycle(r, s, t, g);
         tests_run++;
         if (bus.IF_ID_IR !== exp_ir || bus.IF_ID_NPC !== exp_npc) begin
            tests_failed++;
            $display("FAIL rand[%0d]: got %h/%h expected %h/%h",
                     i, bus.IF_ID_IR, bus.IF_ID_NPC, exp_ir, exp_npc);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      for (int i = 0; i < int'(DEPTH); i++) rom_m[i] = 32'h0;
      rom_m[0] = 32'hA00000AA;
      rom_m[1] = 32'h10000011;
      rom_m[2] = 32'h20000022;
      rom_m[3] = 32'h30000033;
      rom_m[4] = 32'h40000044;
      m_pc           = PCR;
      exp_ir         = 32'h0;
      exp_npc        = 32'h0;
      rst            = 1'b1;
      bus.PC_Src     = 1'b0;
      bus.EX_MEM_NPC = 32'd0;

      test_reset();
      test_sequential();
      test_branch();
      test_alias();
      test_wrap();
      test_priority();
      test_midrun_reset();
      test_random();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
